// File: rtl/dram_pkg.sv
// dram_pkg: shared types and defaults for the cycle-based DRAM model.
// Holds the decoded command enum, the single-bank state enum, the read
// pipeline slot type, the default timing/geometry constants, and the pin
// decoder that turns the raw command strobes into a command.
package dram_pkg;

  // Default geometry and timing, in CK cycles.
  localparam int DEF_ROW_W = 11;
  localparam int DEF_COL_W = 10;
  localparam int DEF_CL    = 5;
  localparam int DEF_TRCD  = 3;
  localparam int DEF_TRP   = 3;

  localparam int DATA_W  = 32;
  localparam int LANES   = 4;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_e;

  typedef enum logic {
    BANK_IDLE = 1'b0,
    BANK_OPEN = 1'b1
  } bank_state_e;

  // One entry of the read-latency pipeline.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_slot_t;

  // Decode the sampled pins. Deselected cycles and unlisted encodings
  // both collapse to NOP; any partial write mask counts as a write.
  function automatic cmd_e decode_cmd(input logic       csn,
                                      input logic       rasn,
                                      input logic       casn,
                                      input logic [3:0] wen);
    cmd_e cmd;
    cmd = CMD_NOP;
    if (!csn) begin
      if (!rasn && casn && (wen == 4'hF))      cmd = CMD_ACT;
      else if (!rasn && casn && (wen == 4'h0)) cmd = CMD_PRE;
      else if (rasn && !casn && (wen == 4'hF)) cmd = CMD_RD;
      else if (rasn && !casn)                  cmd = CMD_WR;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// dram_rd_pipe: CAS-latency delay line for read data.
// A snapshot entered at edge n travels CL-1 further stages and is then
// registered onto Q/VALID at edge n+CL, so VALID is high for exactly the
// cycle following that edge. Q keeps its last delivered value between
// pulses. The whole line clears asynchronously on RSTn so a reset drops
// every read still in flight.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int CL = DEF_CL
) (
  input  logic              CK,
  input  logic              RSTn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] Q,
  output logic              VALID
);

  rd_slot_t stage [CL];

  // Shift the read snapshots one stage per cycle; stage 0 takes the new read.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // loads the value its neighbour held before this edge.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < CL; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{valid: in_valid, data: in_data};
      for (int i = 1; i < CL; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Present the oldest stage on the pins; Q only changes on delivery.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      VALID <= 1'b0;
      Q     <= '0;
    end else begin
      VALID <= stage[CL-1].valid;
      if (stage[CL-1].valid) begin
        Q <= stage[CL-1].data;
      end
    end
  end

endmodule

// File: rtl/dram_model.sv
// dram_model: behavioural model of the off-chip 32-bit single-bank DRAM.
// Decodes ACT/PRE/RD/WR from the multiplexed pins, keeps the open row,
// stores data in four byte-lane arrays (Memory_byte0..3, addressed by
// {row, col} and reached by the bench through hierarchical reference),
// and returns read data CL cycles after the command via dram_rd_pipe.
//
// Build option: define DRAM_TIMING_CHECK_EN to enforce tRCD (ACT to RD/WR)
// and tRP (PRE to ACT). A command that arrives too early is dropped and
// reported with the simulation time. Without it every legal command is
// accepted on the cycle it is sampled.
module dram_model
  import dram_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W,
  parameter int CL    = DEF_CL,
  parameter int TRCD  = DEF_TRCD,
  parameter int TRP   = DEF_TRP
) (
  input  logic              CK,
  input  logic              RSTn,
  input  logic              CSn,
  input  logic              RASn,
  input  logic              CASn,
  input  logic [3:0]        WEn,
  input  logic [ROW_W-1:0]  A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              VALID
);

  localparam int IDX_W     = ROW_W + COL_W;
  localparam int MEM_DEPTH = 2 ** IDX_W;

  // Byte-lane storage; names are fixed for backdoor preload/inspection.
  logic [7:0] Memory_byte0 [MEM_DEPTH];
  logic [7:0] Memory_byte1 [MEM_DEPTH];
  logic [7:0] Memory_byte2 [MEM_DEPTH];
  logic [7:0] Memory_byte3 [MEM_DEPTH];

  cmd_e              cmd;
  bank_state_e       state;
  logic [ROW_W-1:0]  row;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_word;
  logic              trcd_met;
  logic              trp_met;
  logic              act_fire;
  logic              pre_fire;
  logic              rd_fire;
  logic              wr_fire;

  assign cmd      = decode_cmd(CSn, RASn, CASn, WEn);
  assign word_idx = {row, A[COL_W-1:0]};

  // Snapshot of the addressed word as it stands before this edge's write.
  assign rd_word = {Memory_byte3[word_idx], Memory_byte2[word_idx],
                    Memory_byte1[word_idx], Memory_byte0[word_idx]};

  // Qualify decoded commands against bank state and timing.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    act_fire = 1'b0;
    pre_fire = 1'b0;
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    unique case (cmd)
      CMD_ACT: act_fire = (state == BANK_IDLE) && trp_met;
      CMD_PRE: pre_fire = 1'b1;
      CMD_RD:  rd_fire  = (state == BANK_OPEN) && trcd_met;
      CMD_WR:  wr_fire  = (state == BANK_OPEN) && trcd_met;
      default: ;
    endcase
  end

  // Bank state machine: IDLE -(ACT)-> OPEN -(PRE)-> IDLE, row latched on ACT.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state <= BANK_IDLE;
      row   <= '0;
    end else if (pre_fire) begin
      state <= BANK_IDLE;
    end else if (act_fire) begin
      state <= BANK_OPEN;
      row   <= A[ROW_W-1:0];
    end
  end

  // Byte-masked write into the open row at the sampling edge.
  // NOTE: storage is deliberately left out of reset; the bench preloads it
  // after reset and its contents must survive any later reset.
  always_ff @(posedge CK) begin
    if (wr_fire) begin
      if (!WEn[0]) Memory_byte0[word_idx] <= D[7:0];
      if (!WEn[1]) Memory_byte1[word_idx] <= D[15:8];
      if (!WEn[2]) Memory_byte2[word_idx] <= D[23:16];
      if (!WEn[3]) Memory_byte3[word_idx] <= D[31:24];
    end
  end

`ifdef DRAM_TIMING_CHECK_EN
  localparam int TMR_MAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1) + 1;

  // Cycles elapsed since the last ACT / PRE, saturating once satisfied.
  logic [TMR_W-1:0] since_act;
  logic [TMR_W-1:0] since_pre;

  assign trcd_met = (since_act >= TMR_W'(TRCD));
  assign trp_met  = (since_pre >= TMR_W'(TRP));

  // Track ACT/PRE spacing and report commands dropped for arriving early.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      since_act <= TMR_W'(TRCD);
      since_pre <= TMR_W'(TRP);
    end else begin
      if (act_fire) begin
        since_act <= TMR_W'(1);
      end else if (since_act < TMR_W'(TRCD)) begin
        since_act <= since_act + 1'b1;
      end
      if (pre_fire) begin
        since_pre <= TMR_W'(1);
      end else if (since_pre < TMR_W'(TRP)) begin
        since_pre <= since_pre + 1'b1;
      end
      if ((cmd == CMD_RD || cmd == CMD_WR) && state == BANK_OPEN && !trcd_met) begin
        $display("dram_model: tRCD violation, %s ignored at time %0t",
                 (cmd == CMD_RD) ? "RD" : "WR", $time);
      end
      if (cmd == CMD_ACT && state == BANK_IDLE && !trp_met) begin
        $display("dram_model: tRP violation, ACT ignored at time %0t", $time);
      end
    end
  end
`else
  assign trcd_met = 1'b1;
  assign trp_met  = 1'b1;
`endif

  dram_rd_pipe #(
    .CL(CL)
  ) u_rd_pipe (
    .CK      (CK),
    .RSTn    (RSTn),
    .in_valid(rd_fire),
    .in_data (rd_word),
    .Q       (Q),
    .VALID   (VALID)
  );

endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: directed scoreboard bench for dram_model.
// Stimulus pushes the expected word and its due cycle for every read the
// model should accept; a monitor process compares each VALID pulse
// against the head of that queue.
module tb_dram_model;
  import dram_pkg::*;

  localparam int CL   = DEF_CL;
  localparam int TRCD = DEF_TRCD;
  localparam int TRP  = DEF_TRP;

  logic        CK;
  logic        RSTn;
  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        VALID;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   valid_cnt = 0;

  dram_model dut (
    .CK   (CK),
    .RSTn (RSTn),
    .CSn  (CSn),
    .RASn (RASn),
    .CASn (CASn),
    .WEn  (WEn),
    .A    (A),
    .D    (D),
    .Q    (Q),
    .VALID(VALID)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial forever begin
    @(posedge CK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every VALID pulse must match the oldest expected read and
  // arrive on its due cycle; an overdue entry without VALID is a miss.
  initial forever begin
    @(negedge CK);
    if (VALID === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", Q, e.data);
        check("rd_due_cycle", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("rd_valid_missing", {31'b0, VALID}, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  // All drive tasks start #1 after a rising edge and end likewise.
  task automatic drive(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
    @(posedge CK);
    #1;
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic act(input logic [10:0] a);
    drive(1'b0, 1'b0, 1'b1, 4'hF, a, 32'h0);
  endtask

  task automatic pre();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [3:0] wen, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, wen, a, d);
  endtask

  // Read; when 'accept' is set, the expected word is due CL edges later.
  task automatic rd(input logic [10:0] a, input bit accept, input logic [31:0] exp);
    exp_t e;
    drive(1'b0, 1'b1, 1'b0, 4'hF, a, 32'h0);
    if (accept) begin
      e.data = exp;
      e.due  = cyc + CL;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 4 * CL + 20;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic poke(input logic [20:0] idx, input logic [31:0] w);
    dut.Memory_byte0[idx] = w[7:0];
    dut.Memory_byte1[idx] = w[15:8];
    dut.Memory_byte2[idx] = w[23:16];
    dut.Memory_byte3[idx] = w[31:24];
  endtask

  function automatic logic [31:0] peek(input logic [20:0] idx);
    return {dut.Memory_byte3[idx], dut.Memory_byte2[idx],
            dut.Memory_byte1[idx], dut.Memory_byte0[idx]};
  endfunction

  initial begin
    int vc;
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vc;
    RSTn = 1'b0;
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;

    // Reset held while the pins carry activity: outputs stay cleared.
    idle(2);
    act(11'h100);
    rd(11'h000, 1'b0, 32'h0);
    wr(11'h000, 4'h0, 32'hFFFF_FFFF);
    rd(11'h001, 1'b0, 32'h0);
    @(negedge CK);
    check("reset_Q", Q, 32'h0);
    check("reset_VALID", {31'b0, VALID}, 32'd0);
    @(posedge CK);
    #1;
    RSTn = 1'b1;

    poke(21'h40000, 32'h1234_5678);
    poke(21'h40001, 32'hA0B0_C0D1);
    poke(21'h40002, 32'hA0B0_C0D2);
    poke(21'h40003, 32'hA0B0_C0D3);

    // RD with the bank still IDLE after reset: nothing returned.
    vc = valid_cnt;
    rd(11'h000, 1'b0, 32'h0);
    idle(CL + 3);
    check("rd_idle_no_valid", valid_cnt, vc);

    // ACT row 0x100, RD col 0 exactly TRCD later.
    act(11'h100);
    idle(TRCD - 1);
    rd(11'h000, 1'b1, 32'h1234_5678);
    drain();
    idle(2);
    check("Q_holds_after_valid", Q, 32'h1234_5678);

    // Byte-masked write (lanes 3 and 1 enabled), then read back.
    wr(11'h000, 4'b0101, 32'hAABB_CCDD);
    rd(11'h000, 1'b1, 32'hAA34_CC78);
    drain();
    check("backdoor_word0", peek(21'h40000), 32'hAA34_CC78);

    // Opposite mask (lanes 2 and 0) on column 2.
    wr(11'h002, 4'b1010, 32'h1122_3344);
    check("backdoor_word2", peek(21'h40002), 32'hA022_C044);

    // Four back-to-back reads return on consecutive cycles, in order.
    rd(11'h000, 1'b1, 32'hAA34_CC78);
    rd(11'h001, 1'b1, 32'hA0B0_C0D1);
    rd(11'h002, 1'b1, 32'hA022_C044);
    rd(11'h003, 1'b1, 32'hA0B0_C0D3);
    drain();

    // RD, WR same word next edge, RD again: snapshot vs new data.
    rd(11'h001, 1'b1, 32'hA0B0_C0D1);
    wr(11'h001, 4'h0, 32'h5555_5555);
    rd(11'h001, 1'b1, 32'h5555_5555);
    drain();

    // After PRE the bank is closed: RD ignored.
    pre();
    vc = valid_cnt;
    rd(11'h001, 1'b0, 32'h0);
    idle(CL + 3);
    check("rd_after_pre_no_valid", valid_cnt, vc);

    // RD one cycle after ACT: dropped when tRCD is enforced, else returned.
    idle(TRP);
    act(11'h100);
    vc = valid_cnt;
`ifdef DRAM_TIMING_CHECK_EN
    rd(11'h003, 1'b0, 32'h0);
    idle(CL + 3);
    check("early_rd_dropped", valid_cnt, vc);
`else
    rd(11'h003, 1'b1, 32'hA0B0_C0D3);
    drain();
    check("early_rd_returned", valid_cnt, vc + 1);
`endif

    // Reset mid-flight: pending read is flushed and never delivered.
    idle(TRCD);
    rd(11'h001, 1'b1, 32'h5555_5555);
    idle(2);
    RSTn = 1'b0;
    exp_q.delete();
    vc = valid_cnt;
    #1;
    check("midreset_VALID", {31'b0, VALID}, 32'd0);
    check("midreset_Q", Q, 32'h0);
    idle(3);
    RSTn = 1'b1;
    idle(CL + 4);
    check("midreset_no_late_valid", valid_cnt, vc);
    check("memory_survives_reset", peek(21'h40001), 32'h5555_5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
